// File: rtl/armleocpu_muldiv_pkg.sv
// Shared funct3 codes, FSM states and special-case rules for the iterative M-extension unit.
package armleocpu_muldiv_pkg;

  localparam logic [2:0] MULDIV_MUL    = 3'd0;
  localparam logic [2:0] MULDIV_MULH   = 3'd1;
  localparam logic [2:0] MULDIV_MULHSU = 3'd2;
  localparam logic [2:0] MULDIV_MULHU  = 3'd3;
  localparam logic [2:0] MULDIV_DIV    = 3'd4;
  localparam logic [2:0] MULDIV_DIVU   = 3'd5;
  localparam logic [2:0] MULDIV_REM    = 3'd6;
  localparam logic [2:0] MULDIV_REMU   = 3'd7;

  localparam int ITER_COUNT = 32;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  function automatic logic op0_signed(input logic [2:0] f3);
    return (f3 == MULDIV_MUL) || (f3 == MULDIV_MULH) || (f3 == MULDIV_MULHSU) ||
           (f3 == MULDIV_DIV) || (f3 == MULDIV_REM);
  endfunction

  function automatic logic op1_signed(input logic [2:0] f3);
    return (f3 == MULDIV_MUL) || (f3 == MULDIV_MULH) ||
           (f3 == MULDIV_DIV) || (f3 == MULDIV_REM);
  endfunction

  // Divide by zero, signed divide overflow, or multiply by zero.
  function automatic logic special_hit(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (f3[2])
      return (b == 32'd0) || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    return (a == 32'd0) || (b == 32'd0);
  endfunction

  function automatic logic [31:0] special_result(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (!f3[2])       return 32'd0;
    if (b == 32'd0)   return f3[1] ? a : 32'hFFFF_FFFF;
    return f3[1] ? 32'd0 : 32'h8000_0000;
  endfunction

endpackage

// File: rtl/armleocpu_muldiv_if.sv
// Request/response handshake between the execute stage (master) and the mul/div unit (slave).
interface armleocpu_muldiv_if;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_funct3;
  logic [31:0] req_operand0;
  logic [31:0] req_operand1;
  logic        kill;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_result;
  logic        busy;

  modport master (
    output req_valid, req_funct3, req_operand0, req_operand1, kill, resp_ready,
    input  req_ready, resp_valid, resp_result, busy
  );

  modport slave (
    input  req_valid, req_funct3, req_operand0, req_operand1, kill, resp_ready,
    output req_ready, resp_valid, resp_result, busy
  );
endinterface

// File: rtl/armleocpu_divstep.sv
// One restoring-division step: shift in the next dividend bit, subtract divisor if it fits.
module armleocpu_divstep (
  input  logic [32:0] rem_in,
  input  logic [31:0] divisor,
  input  logic        dividend_bit,
  output logic [32:0] rem_out,
  output logic        quot_bit
);
  logic [33:0] shifted;
  logic [32:0] diff;

  assign shifted  = {rem_in, dividend_bit};
  assign quot_bit = (shifted >= {2'b00, divisor});
  assign diff     = shifted[32:0] - {1'b0, divisor};
  assign rem_out  = quot_bit ? diff : shifted[32:0];
endmodule

// File: rtl/armleocpu_muldiv.sv
// Iterative 32-step RV32M multiply/divide unit.
// Define ARMLEOCPU_MULDIV_SPECIAL_FAST_EN to resolve special cases in one cycle.
module armleocpu_muldiv
  import armleocpu_muldiv_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  armleocpu_muldiv_if.slave bus
);
  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [2:0]  f3_q, f3_d;
  logic        sign0_q, sign0_d, sign1_q, sign1_d;
  logic [31:0] mcand_q, mcand_d;
  logic [31:0] op0_q, op0_d, op1_q, op1_d;
  logic [63:0] acc_q, acc_d;
  logic [32:0] rem_q, rem_d;
  logic [31:0] result_q, result_d;
  logic        req_ready_q, req_ready_d, resp_valid_q, resp_valid_d, busy_q, busy_d;

  logic [32:0] div_rem;
  logic        div_qbit;
  logic [32:0] mul_sum;
  logic [63:0] step_acc, prod;
  logic [31:0] quot, remv, final_result;
  logic        neg, in_sign0, in_sign1;
  logic [31:0] in_mag0, in_mag1;

  // mcand_q is the multiplicand for multiplies and the divisor for divides;
  // acc_q[31:0] holds the multiplier or the dividend/quotient shift register.
  armleocpu_divstep u_divstep (
    .rem_in       (rem_q),
    .divisor      (mcand_q),
    .dividend_bit (acc_q[31]),
    .rem_out      (div_rem),
    .quot_bit     (div_qbit)
  );

  always_comb begin
    in_sign0 = op0_signed(bus.req_funct3) & bus.req_operand0[31];
    in_sign1 = op1_signed(bus.req_funct3) & bus.req_operand1[31];
    in_mag0  = in_sign0 ? -bus.req_operand0 : bus.req_operand0;
    in_mag1  = in_sign1 ? -bus.req_operand1 : bus.req_operand1;

    mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, mcand_q} : 33'd0);
    step_acc = f3_q[2] ? {acc_q[63:32], acc_q[30:0], div_qbit} : {mul_sum, acc_q[31:1]};
    neg      = sign0_q ^ sign1_q;
    prod     = neg ? -step_acc : step_acc;
    quot     = neg ? -step_acc[31:0] : step_acc[31:0];
    remv     = sign0_q ? -div_rem[31:0] : div_rem[31:0];

    if (special_hit(f3_q, op0_q, op1_q))
      final_result = special_result(f3_q, op0_q, op1_q);
    else if (f3_q[2])
      final_result = f3_q[1] ? remv : quot;
    else
      final_result = (f3_q == MULDIV_MUL) ? prod[31:0] : prod[63:32];
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    f3_d     = f3_q;
    sign0_d  = sign0_q;
    sign1_d  = sign1_q;
    mcand_d  = mcand_q;
    op0_d    = op0_q;
    op1_d    = op1_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    result_d = result_q;

    case (state_q)
      IDLE: if (bus.req_valid && req_ready_q && !bus.kill) begin
        f3_d    = bus.req_funct3;
        sign0_d = in_sign0;
        sign1_d = in_sign1;
        op0_d   = bus.req_operand0;
        op1_d   = bus.req_operand1;
        mcand_d = bus.req_funct3[2] ? in_mag1 : in_mag0;
        acc_d   = {32'd0, bus.req_funct3[2] ? in_mag0 : in_mag1};
        rem_d   = 33'd0;
        cnt_d   = 5'd0;
        state_d = CALC;
`ifdef ARMLEOCPU_MULDIV_SPECIAL_FAST_EN
        if (special_hit(bus.req_funct3, bus.req_operand0, bus.req_operand1)) begin
          result_d = special_result(bus.req_funct3, bus.req_operand0, bus.req_operand1);
          state_d  = DONE;
        end
`endif
      end
      CALC: begin
        acc_d = step_acc;
        rem_d = f3_q[2] ? div_rem : rem_q;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'(ITER_COUNT - 1)) begin
          result_d = final_result;
          state_d  = DONE;
        end
      end
      DONE: if (bus.resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (bus.kill) state_d = IDLE;

    req_ready_d  = (state_d == IDLE);
    resp_valid_d = (state_d == DONE);
    busy_d       = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= 5'd0;
      f3_q         <= 3'd0;
      sign0_q      <= 1'b0;
      sign1_q      <= 1'b0;
      mcand_q      <= 32'd0;
      op0_q        <= 32'd0;
      op1_q        <= 32'd0;
      acc_q        <= 64'd0;
      rem_q        <= 33'd0;
      result_q     <= 32'd0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      f3_q         <= f3_d;
      sign0_q      <= sign0_d;
      sign1_q      <= sign1_d;
      mcand_q      <= mcand_d;
      op0_q        <= op0_d;
      op1_q        <= op1_d;
      acc_q        <= acc_d;
      rem_q        <= rem_d;
      result_q     <= result_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.req_ready   = req_ready_q;
  assign bus.resp_valid  = resp_valid_q;
  assign bus.resp_result = result_q;
  assign bus.busy        = busy_q;
endmodule

// File: tb/tb_armleocpu_muldiv.sv
// Directed plus randomized checks of armleocpu_muldiv against a 64-bit arithmetic reference.
module tb_armleocpu_muldiv;
  import armleocpu_muldiv_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   fails = 0;

  armleocpu_muldiv_if bus ();
  armleocpu_muldiv dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb, p;
    longint unsigned ua, ub, u;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (f)
      MULDIV_MUL:    begin p = sa * sb; return p[31:0]; end
      MULDIV_MULH:   begin p = sa * sb; return p[63:32]; end
      MULDIV_MULHSU: begin p = sa * longint'(ub); return p[63:32]; end
      MULDIV_MULHU:  begin u = ua * ub; return u[63:32]; end
      MULDIV_DIV:    begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        p = sa / sb; return p[31:0];
      end
      MULDIV_DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
      MULDIV_REM:    begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        p = sa % sb; return p[31:0];
      end
      default:       return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int exp_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
`ifdef ARMLEOCPU_MULDIV_SPECIAL_FAST_EN
    if (f[2] && (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 1;
    if (!f[2] && (a == 0 || b == 0)) return 1;
`endif
    return (f == 3'd0 && a == b) ? 33 : 33;
  endfunction

  function automatic logic [31:0] pick();
    logic [31:0] corners [5];
    corners = '{32'd0, 32'd1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
    if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 4)];
    return $urandom;
  endfunction

  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_funct3 = f; bus.req_operand0 = a; bus.req_operand1 = b;
    while (!bus.req_ready && n < 100) begin @(negedge clk); n++; end
    chk("req_ready_at_issue", 32'(bus.req_ready), 32'd1);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
  endtask

  task automatic wait_resp(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        chk("busy_after_accept", 32'(bus.busy), 32'd1);
        chk("req_ready_low_after_accept", 32'(bus.req_ready), 32'd0);
      end
    end while (!bus.resp_valid && lat < 100);
  endtask

  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp);
    int lat;
    issue(f, a, b);
    wait_resp(lat);
    chk({tag, "_result"}, bus.resp_result, exp);
    chk({tag, "_latency"}, 32'(lat), 32'(exp_lat(f, a, b)));
    bus.resp_ready = 1'b1;
    @(posedge clk);
    #1 bus.resp_ready = 1'b0;
    @(negedge clk);
    chk({tag, "_idle_after_hs"}, {30'd0, bus.req_ready, bus.resp_valid}, 32'd2);
  endtask

  initial begin
    int          lat;
    logic        ok;
    logic [2:0]  f;
    logic [31:0] a, b;

    bus.req_valid = 1'b0; bus.req_funct3 = 3'd0; bus.req_operand0 = 32'd0;
    bus.req_operand1 = 32'd0; bus.kill = 1'b0; bus.resp_ready = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_result", bus.resp_result, 32'd0);
    rst_n = 1'b1;

    run_op("div_neg7_2",  MULDIV_DIV,    32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
    run_op("rem_neg7_2",  MULDIV_REM,    32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
    run_op("divu_by0",    MULDIV_DIVU,   32'd100, 32'd0, 32'hFFFF_FFFF);
    run_op("rem_by0",     MULDIV_REM,    32'h8000_0000, 32'd0, 32'h8000_0000);
    run_op("remu_by0",    MULDIV_REMU,   32'h1234_5678, 32'd0, 32'h1234_5678);
    run_op("div_ovf",     MULDIV_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    run_op("rem_ovf",     MULDIV_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
    run_op("mulh_m1m1",   MULDIV_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0);
    run_op("mulhu_m1m1",  MULDIV_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_op("mulhsu_m1_2", MULDIV_MULHSU, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF);
    run_op("mul_7_6",     MULDIV_MUL,    32'd7, 32'd6, 32'd42);
    run_op("mul_zero",    MULDIV_MUL,    32'd0, 32'hDEAD_BEEF, 32'd0);

    // kill together with req_valid must not start an operation
    @(negedge clk);
    bus.req_valid = 1'b1; bus.kill = 1'b1; bus.req_funct3 = MULDIV_DIVU;
    bus.req_operand0 = 32'd50; bus.req_operand1 = 32'd5;
    @(posedge clk);
    #1 bus.req_valid = 1'b0; bus.kill = 1'b0;
    @(negedge clk);
    chk("kill_with_req_busy", 32'(bus.busy), 32'd0);

    // kill mid-CALC
    issue(MULDIV_DIVU, 32'd1000, 32'd7);
    repeat (10) @(negedge clk);
    bus.kill = 1'b1;
    @(posedge clk);
    #1 bus.kill = 1'b0;
    @(negedge clk);
    chk("kill_req_ready", 32'(bus.req_ready), 32'd1);
    chk("kill_busy", 32'(bus.busy), 32'd0);
    ok = 1'b1;
    repeat (40) begin @(negedge clk); if (bus.resp_valid !== 1'b0) ok = 1'b0; end
    chk("kill_no_resp", 32'(ok), 32'd1);
    run_op("after_kill_9_3", MULDIV_DIVU, 32'd9, 32'd3, 32'd3);

    // reset mid-CALC
    issue(MULDIV_DIVU, 32'd1000, 32'd7);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_idle", {29'd0, bus.req_ready, bus.busy, bus.resp_valid}, 32'd4);
    chk("midrst_result", bus.resp_result, 32'd0);
    run_op("after_rst_1000_7", MULDIV_DIVU, 32'd1000, 32'd7, 32'd142);

    // resp_ready held low, then back-to-back issue one cycle after the handshake
    issue(MULDIV_DIV, 32'hFFFF_FFF9, 32'd2);
    wait_resp(lat);
    chk("hold_result", bus.resp_result, 32'hFFFF_FFFD);
    ok = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (bus.resp_result !== 32'hFFFF_FFFD || bus.busy !== 1'b1 ||
          bus.req_ready !== 1'b0 || bus.resp_valid !== 1'b1) ok = 1'b0;
    end
    chk("hold_stable", 32'(ok), 32'd1);
    bus.resp_ready = 1'b1;
    @(posedge clk);
    #1 bus.resp_ready = 1'b0;
    bus.req_valid = 1'b1; bus.req_funct3 = MULDIV_REM;
    bus.req_operand0 = 32'hFFFF_FFF9; bus.req_operand1 = 32'd2;
    @(negedge clk);
    chk("ready_after_hs", 32'(bus.req_ready), 32'd1);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    wait_resp(lat);
    chk("b2b_result", bus.resp_result, 32'hFFFF_FFFF);
    chk("b2b_latency", 32'(lat), 32'd33);
    bus.resp_ready = 1'b1;
    @(posedge clk);
    #1 bus.resp_ready = 1'b0;

    for (int i = 0; i < 30; i++) begin
      f = 3'($urandom_range(0, 7));
      a = pick();
      b = pick();
      run_op($sformatf("rand%0d_f%0d", i, f), f, a, b, ref_op(f, a, b));
    end

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed no finish, required finish");
    $fatal(1, "timeout");
  end
endmodule
